// File: rtl/dce_pkg.sv
// Shared constants for the DCE02 encoder input-conditioning path.
package dce_pkg;

    localparam int SYNC_STAGES     = 2;
    localparam int DB_TICK_DIV_DEF = 50000;
    localparam int DB_STABLE_N_DEF = 8;

    // Width of a counter that must hold values 0..n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sw_debounce8_db_bit.sv
// One debounced line: synchroniser, accepted level q, and a run counter of
// tick samples that disagree with q.
module db_bit
    import dce_pkg::*;
#(
    parameter int STABLE_N = DB_STABLE_N_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic q,
    output logic flip
);

    localparam int CW = cnt_width(STABLE_N);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_N - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CW-1:0]          cnt;

    assign s = sync[SYNC_STAGES-1];

    // Combinational so the top can register chg on the same edge q moves.
    assign flip = tick && (s != q) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= 1'b0;
            cnt <= '0;
        end else if (tick) begin
            if (s == q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                q   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_debounce8.sv
// Debounces eight switch levels plus an enable switch against a shared
// sample tick and flags settled changes of the switch vector.
module sw_debounce8
    import dce_pkg::*;
#(
    parameter int TICK_DIV = DB_TICK_DIV_DEF,
    parameter int STABLE_N = DB_STABLE_N_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       en_sw,
    output logic [7:0] x,
    output logic       en,
    output logic       chg
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [7:0]    x_flip;
    logic          en_flip_unused;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_sw
        db_bit #(.STABLE_N(STABLE_N)) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .raw  (sw[i]),
            .q    (x[i]),
            .flip (x_flip[i])
        );
    end

    // The enable line settles on its own and deliberately never raises chg.
    db_bit #(.STABLE_N(STABLE_N)) u_db_en (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick),
        .raw  (en_sw),
        .q    (en),
        .flip (en_flip_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg <= 1'b0;
        end else begin
            chg <= |x_flip;
        end
    end

endmodule

// File: tb/tb_sw_debounce8.sv
// Bench for sw_debounce8: two configurations driven together and compared
// every cycle against a sample-history model, plus directed timing checks.
module tb_sw_debounce8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] sw = 8'h00;
    logic       en_sw = 1'b0;
    logic [7:0] x0, x1;
    logic       en0, en1, chg0, chg1;

    int checks = 0;
    int errors = 0;

    // Reference model, index 0: TICK_DIV=4/STABLE_N=3, index 1: 1/1.
    bit s1m [2][9];
    bit sm  [2][9];
    bit qm  [2][9];
    bit chgm[2];
    int km  [2];
    bit hist[2][9][$];

    int chg_cnt0, chg_cnt1;

    always #5 clk = ~clk;

    sw_debounce8 #(.TICK_DIV(4), .STABLE_N(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .sw(sw), .en_sw(en_sw),
        .x(x0), .en(en0), .chg(chg0)
    );

    sw_debounce8 #(.TICK_DIV(1), .STABLE_N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sw(sw), .en_sw(en_sw),
        .x(x1), .en(en1), .chg(chg1)
    );

    function automatic int tdiv(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int stn(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic logic [8:0] mq(input int d);
        logic [8:0] v;
        for (int b = 0; b < 9; b++) v[b] = qm[d][b];
        return v;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            km[d]   = 0;
            chgm[d] = 1'b0;
            for (int b = 0; b < 9; b++) begin
                s1m[d][b] = 1'b0;
                sm[d][b]  = 1'b0;
                qm[d][b]  = 1'b0;
                hist[d][b].delete();
            end
        end
    endtask

    // A line accepts a new level once its last STABLE_N tick samples taken
    // since the previous acceptance all disagree with the accepted level.
    task automatic model_edge();
        logic [8:0] raw;
        bit         all_diff;
        raw = {en_sw, sw};
        if (!rst_n) begin
            model_clear();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            km[d]   = km[d] + 1;
            chgm[d] = 1'b0;
            if ((km[d] % tdiv(d)) == 0) begin
                for (int b = 0; b < 9; b++) begin
                    hist[d][b].push_back(sm[d][b]);
                    if (hist[d][b].size() > stn(d)) void'(hist[d][b].pop_front());
                    if (hist[d][b].size() == stn(d)) begin
                        all_diff = 1'b1;
                        for (int i = 0; i < hist[d][b].size(); i++)
                            if (hist[d][b][i] == qm[d][b]) all_diff = 1'b0;
                        if (all_diff) begin
                            qm[d][b] = ~qm[d][b];
                            hist[d][b].delete();
                            if (b < 8) chgm[d] = 1'b1;
                        end
                    end
                end
            end
            for (int b = 0; b < 9; b++) begin
                sm[d][b]  = s1m[d][b];
                s1m[d][b] = raw[b];
            end
        end
    endtask

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [8:0] m0, m1;
        m0 = mq(0);
        m1 = mq(1);
        check("x0",   {1'b0, x0},   {1'b0, m0[7:0]});
        check("en0",  {8'h00, en0},  {8'h00, m0[8]});
        check("chg0", {8'h00, chg0}, {8'h00, chgm[0]});
        check("x1",   {1'b0, x1},   {1'b0, m1[7:0]});
        check("en1",  {8'h00, en1},  {8'h00, m1[8]});
        check("chg1", {8'h00, chg1}, {8'h00, chgm[1]});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        chg_cnt0 += int'(chg0);
        chg_cnt1 += int'(chg1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int         lat;
        bit         found;
        logic       chg_at;
        logic       x3_seen;
        int         idx;
        int         r;

        model_clear();

        // Reset with all inputs high: outputs clear immediately.
        sw    = 8'hFF;
        en_sw = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_x",   {1'b0, x0},  9'h000);
        check("rst_en",  {8'h00, en0}, 9'h000);
        check("rst_chg", {8'h00, chg0}, 9'h000);
        run(3);
        rst_n    = 1'b1;
        chg_cnt0 = 0;
        run(13);
        check("rel_x",    {1'b0, x0},   9'h0FF);
        check("rel_en",   {8'h00, en0},  9'h001);
        check("rel_chg_n", 9'(chg_cnt0), 9'd1);

        // Clean step from 0 to 8'h84.
        sw    = 8'h00;
        en_sw = 1'b0;
        run(20);
        sw       = 8'h84;
        chg_cnt0 = 0;
        found    = 1'b0;
        lat      = 0;
        chg_at   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (!found && x0 == 8'h84) begin
                found  = 1'b1;
                lat    = i - 1;
                chg_at = chg0;
            end
        end
        check("step_found", {8'h00, found}, 9'h001);
        check("step_lat_ok", {8'h00, (lat >= 10 && lat <= 13)}, 9'h001);
        check("step_chg_at", {8'h00, chg_at}, 9'h001);
        check("step_chg_n", 9'(chg_cnt0), 9'd1);

        // Bounce on sw[3] shorter than three ticks is rejected.
        sw = 8'h00;
        run(20);
        chg_cnt0 = 0;
        x3_seen  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i % 5 == 0) sw[3] = ~sw[3];
            step();
            x3_seen |= x0[3];
        end
        sw[3] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            x3_seen |= x0[3];
        end
        check("bounce_x3", {8'h00, x3_seen}, 9'h000);
        check("bounce_chg_n", 9'(chg_cnt0), 9'd0);

        // Enable alone never raises chg.
        sw = 8'h10;
        run(20);
        chg_cnt0 = 0;
        en_sw    = 1'b1;
        run(20);
        check("enonly_en", {8'h00, en0}, 9'h001);
        check("enonly_x",  {1'b0, x0},  9'h010);
        check("enonly_chg_n", 9'(chg_cnt0), 9'd0);

        // Reset mid-count discards partial runs.
        sw    = 8'h00;
        en_sw = 1'b0;
        run(20);
        sw = 8'h01;
        run(8);
        rst_n = 1'b0;
        #1;
        check("midrst_x",   {1'b0, x0},   9'h000);
        check("midrst_chg", {8'h00, chg0}, 9'h000);
        model_clear();
        run(2);
        rst_n = 1'b1;
        run(11);
        check("midrst_early", {1'b0, x0}, 9'h000);
        run(1);
        check("midrst_acc",     {1'b0, x0},   9'h001);
        check("midrst_acc_chg", {8'h00, chg0}, 9'h001);

        // Boundary configuration: accept exactly at edge 2 after capture.
        sw = 8'h00;
        run(5);
        sw = 8'h80;
        step();
        check("b1_e0", {1'b0, x1}, 9'h000);
        step();
        check("b1_e1", {1'b0, x1}, 9'h000);
        step();
        check("b1_e2_x",   {1'b0, x1},   9'h080);
        check("b1_e2_chg", {8'h00, chg1}, 9'h001);

        // Random toggles, byte writes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                idx = int'($urandom_range(0, 8));
                if (idx == 8) en_sw = ~en_sw;
                else          sw[idx] = ~sw[idx];
            end else if (r == 1 && $urandom_range(0, 7) == 0) begin
                sw = 8'($urandom);
            end
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
